rvsteel_gpio_arbiter: RTL and testbench

//   Shares one GPIO register port between two bus masters (m0: CPU, m1: sequencer/DMA).

---
 rtl/rvsteel_gpio_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_rvsteel_gpio_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_gpio_arbiter.sv
// Round-robin arbiter sharing one GPIO register port between two bus masters.
// Optional WAIT-state timeout enabled by defining RVSTEEL_GPIO_ARB_TIMEOUT_EN.
module rvsteel_gpio_arbiter #(
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_rw_address,
    output logic [31:0]           m0_read_data,
    input  logic                  m0_read_request,
    output logic                  m0_read_response,
    input  logic [31:0]           m0_write_data,
    input  logic [3:0]            m0_write_strobe,
    input  logic                  m0_write_request,
    output logic                  m0_write_response,
    input  logic [ADDR_WIDTH-1:0] m1_rw_address,
    output logic [31:0]           m1_read_data,
    input  logic                  m1_read_request,
    output logic                  m1_read_response,
    input  logic [31:0]           m1_write_data,
    input  logic [3:0]            m1_write_strobe,
    input  logic                  m1_write_request,
    output logic                  m1_write_response,
    output logic [ADDR_WIDTH-1:0] dev_rw_address,
    input  logic [31:0]           dev_read_data,
    output logic                  dev_read_request,
    input  logic                  dev_read_response,
    output logic [31:0]           dev_write_data,
    output logic [3:0]            dev_write_strobe,
    output logic                  dev_write_request,
    input  logic                  dev_write_response,
    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0] dev_addr_q, dev_addr_d;
    logic [31:0]           dev_wdata_q, dev_wdata_d;
    logic [3:0]            dev_strobe_q, dev_strobe_d;
    logic                  dev_rreq_q, dev_rreq_d;
    logic                  dev_wreq_q, dev_wreq_d;
    logic [31:0]           m0_rdata_q, m0_rdata_d;
    logic [31:0]           m1_rdata_q, m1_rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [1:0]            wresp_q, wresp_d;

    logic                  pend0, pend1, sel, rsp_hit, timeout_hit;
    logic [31:0]           resp_data;

`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign pend0   = m0_read_request | m0_write_request;
    assign pend1   = m1_read_request | m1_write_request;
    assign rsp_hit = is_read_q ? dev_read_response : dev_write_response;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        is_read_d    = is_read_q;
        dev_addr_d   = dev_addr_q;
        dev_wdata_d  = dev_wdata_q;
        dev_strobe_d = dev_strobe_q;
        dev_rreq_d   = 1'b0;
        dev_wreq_d   = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        rresp_d      = 2'b00;
        wresp_d      = 2'b00;
        sel          = 1'b0;
        resp_data    = 32'h0;
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pend0 | pend1) begin
                    // On a tie the master that did not win last time goes next.
                    sel          = (pend0 & pend1) ? ~last_grant_q : pend1;
                    state_d      = ISSUE;
                    grant_d      = sel ? 2'b10 : 2'b01;
                    last_grant_d = sel;
                    if (sel) begin
                        is_read_d    = m1_read_request;
                        dev_addr_d   = m1_rw_address;
                        dev_wdata_d  = m1_write_data;
                        dev_strobe_d = m1_write_strobe;
                    end else begin
                        is_read_d    = m0_read_request;
                        dev_addr_d   = m0_rw_address;
                        dev_wdata_d  = m0_write_data;
                        dev_strobe_d = m0_write_strobe;
                    end
                    dev_rreq_d = is_read_d;
                    dev_wreq_d = ~is_read_d;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (rsp_hit | timeout_hit) begin
                    state_d = RESP;
                    if (is_read_q) begin
                        // A timed-out read returns zero rather than stale bus data.
                        resp_data = rsp_hit ? dev_read_data : 32'h0;
                        rresp_d   = grant_q;
                        if (grant_q[0]) m0_rdata_d = resp_data;
                        if (grant_q[1]) m1_rdata_d = resp_data;
                    end else begin
                        wresp_d = grant_q;
                    end
                end else begin
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                state_d      = IDLE;
                grant_d      = 2'b00;
                dev_addr_d   = '0;
                dev_wdata_d  = 32'h0;
                dev_strobe_d = 4'h0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            is_read_q    <= 1'b0;
            dev_addr_q   <= '0;
            dev_wdata_q  <= 32'h0;
            dev_strobe_q <= 4'h0;
            dev_rreq_q   <= 1'b0;
            dev_wreq_q   <= 1'b0;
            m0_rdata_q   <= 32'h0;
            m1_rdata_q   <= 32'h0;
            rresp_q      <= 2'b00;
            wresp_q      <= 2'b00;
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            is_read_q    <= is_read_d;
            dev_addr_q   <= dev_addr_d;
            dev_wdata_q  <= dev_wdata_d;
            dev_strobe_q <= dev_strobe_d;
            dev_rreq_q   <= dev_rreq_d;
            dev_wreq_q   <= dev_wreq_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            rresp_q      <= rresp_d;
            wresp_q      <= wresp_d;
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign m0_read_data      = m0_rdata_q;
    assign m1_read_data      = m1_rdata_q;
    assign m0_read_response  = rresp_q[0];
    assign m1_read_response  = rresp_q[1];
    assign m0_write_response = wresp_q[0];
    assign m1_write_response = wresp_q[1];
    assign dev_rw_address    = dev_addr_q;
    assign dev_write_data    = dev_wdata_q;
    assign dev_write_strobe  = dev_strobe_q;
    assign dev_read_request  = dev_rreq_q;
    assign dev_write_request = dev_wreq_q;
    assign grant             = grant_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_rvsteel_gpio_arbiter.sv
// Bench for rvsteel_gpio_arbiter: transaction-level model plus directed scenarios.
// Timeout scenario follows RVSTEEL_GPIO_ARB_TIMEOUT_EN.
module tb_rvsteel_gpio_arbiter;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] m0_rw_address = '0, m1_rw_address = '0;
    logic [31:0]   m0_read_data, m1_read_data;
    logic          m0_read_request = 1'b0, m1_read_request = 1'b0;
    logic          m0_read_response, m1_read_response;
    logic [31:0]   m0_write_data = '0, m1_write_data = '0;
    logic [3:0]    m0_write_strobe = '0, m1_write_strobe = '0;
    logic          m0_write_request = 1'b0, m1_write_request = 1'b0;
    logic          m0_write_response, m1_write_response;
    logic [AW-1:0] dev_rw_address;
    logic [31:0]   dev_read_data;
    logic          dev_read_request, dev_read_response;
    logic [31:0]   dev_write_data;
    logic [3:0]    dev_write_strobe;
    logic          dev_write_request, dev_write_response;
    logic [1:0]    grant;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit dev_silent = 1'b0;
    bit inj_rd     = 1'b0;

    rvsteel_gpio_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .m0_rw_address(m0_rw_address), .m0_read_data(m0_read_data),
        .m0_read_request(m0_read_request), .m0_read_response(m0_read_response),
        .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
        .m0_write_request(m0_write_request), .m0_write_response(m0_write_response),
        .m1_rw_address(m1_rw_address), .m1_read_data(m1_read_data),
        .m1_read_request(m1_read_request), .m1_read_response(m1_read_response),
        .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
        .m1_write_request(m1_write_request), .m1_write_response(m1_write_response),
        .dev_rw_address(dev_rw_address), .dev_read_data(dev_read_data),
        .dev_read_request(dev_read_request), .dev_read_response(dev_read_response),
        .dev_write_data(dev_write_data), .dev_write_strobe(dev_write_strobe),
        .dev_write_request(dev_write_request), .dev_write_response(dev_write_response),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dev_val(input logic [AW-1:0] a);
        return (a == '0) ? 32'h3 : (32'hC0DE_0000 | 32'(a));
    endfunction

    // GPIO device: answers a request pulse one cycle later with a one-cycle response.
    initial begin
        logic rq, wq;
        logic [AW-1:0] ra;
        dev_read_response  = 1'b0;
        dev_write_response = 1'b0;
        dev_read_data      = 32'h0;
        forever begin
            @(negedge clock); #1;
            rq = (!dev_silent && dev_read_request) || inj_rd;
            wq = !dev_silent && dev_write_request;
            ra = dev_rw_address;
            @(posedge clock); #1;
            dev_read_response  = rq;
            dev_write_response = wq;
            dev_read_data      = rq ? dev_val(ra) : 32'hDEAD_BEEF;
        end
    end

    // Transaction model: one owner at a time, issue, wait for answer, respond, release.
    logic [1:0]    e_grant = '0;
    logic          e_busy = 1'b0, e_rreq = 1'b0, e_wreq = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0]   e_wdata = '0;
    logic [3:0]    e_strb = '0;
    logic [31:0]   e_rdata [2];
    logic          e_rresp [2];
    logic          e_wresp [2];
    bit            mo_on = 1'b0;

    initial begin
        int owner, sel, waited;
        bit last, rd, issued, answered, p0, p1;
        owner = -1; last = 1'b1; rd = 1'b0; issued = 1'b0; answered = 1'b0; waited = 0;
        for (int i = 0; i < 2; i++) begin
            e_rdata[i] = '0; e_rresp[i] = 1'b0; e_wresp[i] = 1'b0;
        end
        forever begin
            @(posedge clock);
            e_rreq = 1'b0; e_wreq = 1'b0;
            for (int i = 0; i < 2; i++) begin e_rresp[i] = 1'b0; e_wresp[i] = 1'b0; end
            if (reset) begin
                mo_on = 1'b1; owner = -1; last = 1'b1;
                e_grant = '0; e_busy = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
                e_rdata[0] = '0; e_rdata[1] = '0;
            end else if (owner < 0) begin
                p0 = m0_read_request | m0_write_request;
                p1 = m1_read_request | m1_write_request;
                if (p0 || p1) begin
                    sel = (p0 && p1) ? (last ? 0 : 1) : (p0 ? 0 : 1);
                    owner = sel; last = (sel == 1);
                    rd      = (sel == 1) ? m1_read_request : m0_read_request;
                    e_addr  = (sel == 1) ? m1_rw_address : m0_rw_address;
                    e_wdata = (sel == 1) ? m1_write_data : m0_write_data;
                    e_strb  = (sel == 1) ? m1_write_strobe : m0_write_strobe;
                    e_grant = (sel == 1) ? 2'b10 : 2'b01;
                    e_busy  = 1'b1;
                    e_rreq  = rd; e_wreq = !rd;
                    issued = 1'b0; answered = 1'b0;
                end
            end else if (!issued) begin
                issued = 1'b1; waited = 0;
            end else if (!answered) begin
                waited++;
                if (rd ? dev_read_response : dev_write_response) begin
                    answered = 1'b1;
                    if (rd) begin e_rresp[owner] = 1'b1; e_rdata[owner] = dev_read_data; end
                    else e_wresp[owner] = 1'b1;
                end
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
                else if (waited == TO) begin
                    answered = 1'b1;
                    if (rd) begin e_rresp[owner] = 1'b1; e_rdata[owner] = 32'h0; end
                    else e_wresp[owner] = 1'b1;
                end
`endif
            end else begin
                owner = -1;
                e_grant = '0; e_busy = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    initial begin
        forever begin
            @(posedge clock); #2;
            if (mo_on) begin
                chk("grant", 32'(grant), 32'(e_grant));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("dev_rw_address", 32'(dev_rw_address), 32'(e_addr));
                chk("dev_write_data", dev_write_data, e_wdata);
                chk("dev_write_strobe", 32'(dev_write_strobe), 32'(e_strb));
                chk("dev_read_request", 32'(dev_read_request), 32'(e_rreq));
                chk("dev_write_request", 32'(dev_write_request), 32'(e_wreq));
                chk("m0_read_data", m0_read_data, e_rdata[0]);
                chk("m1_read_data", m1_read_data, e_rdata[1]);
                chk("m0_read_response", 32'(m0_read_response), 32'(e_rresp[0]));
                chk("m1_read_response", 32'(m1_read_response), 32'(e_rresp[1]));
                chk("m0_write_response", 32'(m0_write_response), 32'(e_wresp[0]));
                chk("m1_write_response", 32'(m1_write_response), 32'(e_wresp[1]));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_m0_read_data", m0_read_data, 32'h0);
        chk("rst_dev_read_request", 32'(dev_read_request), 32'h0);

        // 1: single m0 read of address 0
        m0_rw_address = 5'h00; m0_read_request = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                chk("t1_dev_rreq", 32'(dev_read_request), 32'h1);
                chk("t1_grant", 32'(grant), 32'h1);
            end
            if (k == 2) chk("t1_early_resp", 32'(m0_read_response), 32'h0);
            if (k == 3) begin
                chk("t1_m0_rresp", 32'(m0_read_response), 32'h1);
                chk("t1_m0_rdata", m0_read_data, 32'h3);
                chk("t1_m1_rdata", m1_read_data, 32'h0);
                chk("t1_m1_rresp", 32'(m1_read_response), 32'h0);
                m0_read_request = 1'b0;
            end
            if (k == 4) chk("t1_idle", 32'(busy), 32'h0);
        end

        // 2: simultaneous writes, m0 wins the first tie
        do_reset();
        m0_rw_address = 5'h04; m0_write_data = 32'h1; m0_write_strobe = 4'hF; m0_write_request = 1'b1;
        m1_rw_address = 5'h08; m1_write_data = 32'h2; m1_write_strobe = 4'hF; m1_write_request = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                chk("t2_wreq1", 32'(dev_write_request), 32'h1);
                chk("t2_addr1", 32'(dev_rw_address), 32'h04);
                chk("t2_data1", dev_write_data, 32'h1);
            end
            if (k == 3) begin
                chk("t2_m0_wresp", 32'(m0_write_response), 32'h1);
                m0_write_request = 1'b0;
            end
            if (k == 4) chk("t2_gap_idle", 32'(busy), 32'h0);
            if (k == 5) begin
                chk("t2_wreq2", 32'(dev_write_request), 32'h1);
                chk("t2_addr2", 32'(dev_rw_address), 32'h08);
                chk("t2_grant2", 32'(grant), 32'h2);
            end
            if (k == 7) begin
                chk("t2_m1_wresp", 32'(m1_write_response), 32'h1);
                m1_write_request = 1'b0;
            end
        end

        // 3: m0 streams reads, m1 slips into the second slot
        do_reset();
        m0_rw_address = 5'h01; m0_read_request = 1'b1;
        m1_rw_address = 5'h06;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) m1_read_request = 1'b1;
            if (k == 1) chk("t3_slot1", 32'(grant), 32'h1);
            if (k == 5) chk("t3_slot2", 32'(grant), 32'h2);
            if (k == 7) begin
                chk("t3_m1_rresp", 32'(m1_read_response), 32'h1);
                chk("t3_m1_rdata", m1_read_data, 32'hC0DE_0006);
                m1_read_request = 1'b0;
            end
            if (k == 9) chk("t3_slot3", 32'(grant), 32'h1);
            if (k == 11) chk("t3_m0_rdata", m0_read_data, 32'hC0DE_0001);
        end
        m0_read_request = 1'b0;
        for (int k = 0; k < 10 && busy; k++) tick();
        chk("t3_drain", 32'(busy), 32'h0);

        // 4: reset during WAIT aborts silently
        do_reset();
        m0_rw_address = 5'h02; m0_read_request = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_grant", 32'(grant), 32'h0);
        chk("t4_no_resp", 32'(m0_read_response), 32'h0);
        reset = 1'b0; m0_read_request = 1'b0;
        tick();
        m1_rw_address = 5'h05; m1_read_request = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) chk("t4_grant_m1", 32'(grant), 32'h2);
            if (k == 2) chk("t4_m1_early", 32'(m1_read_response), 32'h0);
            if (k == 3) begin
                chk("t4_m1_rresp", 32'(m1_read_response), 32'h1);
                chk("t4_m1_rdata", m1_read_data, 32'hC0DE_0005);
                m1_read_request = 1'b0;
            end
        end
        tick();

        // 5: silent device
        dev_silent = 1'b1;
        m1_rw_address = 5'h03; m1_read_request = 1'b1;
`ifdef RVSTEEL_GPIO_ARB_TIMEOUT_EN
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 17) chk("t5_still_wait", 32'(m1_read_response), 32'h0);
            if (k == 18) begin
                chk("t5_to_rresp", 32'(m1_read_response), 32'h1);
                chk("t5_to_rdata", m1_read_data, 32'h0);
                m1_read_request = 1'b0;
            end
            if (k == 19) begin chk("t5_idle", 32'(busy), 32'h0); inj_rd = 1'b1; end
            if (k == 20) inj_rd = 1'b0;
            if (k == 21) begin
                chk("t5_late_ignored", 32'(busy), 32'h0);
                chk("t5_late_no_resp", 32'(m1_read_response), 32'h0);
            end
        end
        dev_silent = 1'b0;
`else
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 18) begin
                chk("t5_busy18", 32'(busy), 32'h1);
                chk("t5_no_resp18", 32'(m1_read_response), 32'h0);
            end
            if (k == 30) chk("t5_busy30", 32'(busy), 32'h1);
        end
        m1_read_request = 1'b0;
        dev_silent = 1'b0;
        do_reset();
`endif

        // 6: read and write raised together, read wins
        do_reset();
        m0_rw_address = 5'h08; m0_write_data = 32'h55; m0_write_strobe = 4'h3;
        m0_read_request = 1'b1; m0_write_request = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                chk("t6_rreq", 32'(dev_read_request), 32'h1);
                chk("t6_no_wreq", 32'(dev_write_request), 32'h0);
            end
            if (k == 3) begin
                chk("t6_rresp", 32'(m0_read_response), 32'h1);
                chk("t6_no_wresp", 32'(m0_write_response), 32'h0);
                chk("t6_rdata", m0_read_data, 32'hC0DE_0008);
                m0_read_request = 1'b0; m0_write_request = 1'b0;
            end
        end
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
